// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencing controller for the MIPS datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath controls as registered Moore decodes of the state and latched IR.
// Ports:
//   clk, reset (async active-low), run (fetch permit),
//   opcode/func (instr fields from IFU), zero (ALU flag, datapath only),
//   PCWR/IRWR/RFWR/DMWR strobes, ALUOP/NPCOP/EXTOP/WRSEL/WDSEL/BSEL/WBH
//   static fields, state, illegal pulse, retired instruction counter.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  output logic        PCWR,
  output logic        IRWR,
  output logic        RFWR,
  output logic        DMWR,
  output logic [2:0]  ALUOP,
  output logic [2:0]  NPCOP,
  output logic [1:0]  EXTOP,
  output logic [1:0]  WRSEL,
  output logic [1:0]  WDSEL,
  output logic        BSEL,
  output logic [1:0]  WBH,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  // Instruction classes; each determines the state path and final cycle.
  typedef enum logic [2:0] {ClsIll, ClsAlu, ClsLoad, ClsStore, ClsBr, ClsJal} cls_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d, fn_q, fn_d;
  logic [31:0] retired_q, retired_d;
  logic        pcwr_q, irwr_q, rfwr_q, dmwr_q, bsel_q, illegal_q;
  logic [2:0]  aluop_q, npcop_q;
  logic [1:0]  extop_q, wrsel_q, wdsel_q, wbh_q;

  cls_e        cls;
  logic [2:0]  dec_aluop, dec_npcop;
  logic [1:0]  dec_extop, dec_wrsel, dec_wdsel, dec_wbh;
  logic        dec_bsel;
  logic        active_d;

  // The FSM never branches on zero; it is consumed by the datapath through NPCOP.
  logic unused_zero;
  assign unused_zero = zero;

  function automatic logic is_final(state_e st, cls_e c);
    return (st == StExec && (c == ClsBr || c == ClsIll)) ||
           (st == StMem && c == ClsStore) || (st == StWb);
  endfunction

  // IR latch: loaded on the edge that leaves FETCH.
  always_comb begin
    op_d = op_q;
    fn_d = fn_q;
    if (state_q == StFetch) begin
      op_d = opcode;
      fn_d = func;
    end
  end

  // Decode of the (next) latched instruction; illegal leaves every field at 0.
  always_comb begin
    cls       = ClsIll;
    dec_aluop = 3'b000;
    dec_npcop = 3'b000;
    dec_extop = 2'b00;
    dec_wrsel = 2'b00;
    dec_wdsel = 2'b00;
    dec_bsel  = 1'b0;
    dec_wbh   = 2'b00;
    case (op_d)
      6'b000000: begin
        case (fn_d)
          6'b100001: begin cls = ClsAlu; dec_wrsel = 2'b01; end
          6'b100011: begin cls = ClsAlu; dec_aluop = 3'b001; dec_wrsel = 2'b01; end
          6'b000000: begin cls = ClsAlu; dec_aluop = 3'b011; dec_wrsel = 2'b01; end
          6'b001000: begin cls = ClsBr;  dec_npcop = 3'b011; end
          default: ;
        endcase
      end
      6'b001101: begin cls = ClsAlu; dec_aluop = 3'b010; dec_bsel = 1'b1; end
      6'b001111: begin
        cls = ClsAlu; dec_aluop = 3'b100; dec_bsel = 1'b1; dec_extop = 2'b10;
      end
      6'b100011, 6'b100000, 6'b100001: begin
        cls = ClsLoad; dec_bsel = 1'b1; dec_extop = 2'b01; dec_wdsel = 2'b01;
        dec_wbh = (op_d == 6'b100000) ? 2'b01 : (op_d == 6'b100001) ? 2'b10 : 2'b00;
      end
      6'b101011, 6'b101000, 6'b101001: begin
        cls = ClsStore; dec_bsel = 1'b1; dec_extop = 2'b01;
        dec_wbh = (op_d == 6'b101000) ? 2'b01 : (op_d == 6'b101001) ? 2'b10 : 2'b00;
      end
      6'b000100: begin cls = ClsBr; dec_aluop = 3'b001; dec_npcop = 3'b001; end
      6'b000010: begin cls = ClsBr; dec_npcop = 3'b010; end
      6'b000011: begin
        cls = ClsJal; dec_npcop = 3'b010; dec_wrsel = 2'b10; dec_wdsel = 2'b10;
      end
      default: ;
    endcase
  end

  // Next state; run is only consulted in IDLE and on an instruction's final cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      default: begin
        if (is_final(state_q, cls)) begin
          state_d = run ? StFetch : StIdle;
        end else if (state_q == StExec && (cls == ClsLoad || cls == ClsStore)) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
    endcase
  end

  assign active_d  = (state_d != StIdle) && (state_d != StFetch);
  assign retired_d = pcwr_q ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= 6'd0;
      fn_q      <= 6'd0;
      retired_q <= 32'd0;
      pcwr_q    <= 1'b0;
      irwr_q    <= 1'b0;
      rfwr_q    <= 1'b0;
      dmwr_q    <= 1'b0;
      illegal_q <= 1'b0;
      aluop_q   <= 3'b000;
      npcop_q   <= 3'b000;
      extop_q   <= 2'b00;
      wrsel_q   <= 2'b00;
      wdsel_q   <= 2'b00;
      bsel_q    <= 1'b0;
      wbh_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      retired_q <= retired_d;
      pcwr_q    <= is_final(state_d, cls);
      irwr_q    <= (state_d == StFetch);
      rfwr_q    <= (state_d == StWb);
      dmwr_q    <= (state_d == StMem) && (cls == ClsStore);
      illegal_q <= (state_d == StExec) && (cls == ClsIll);
      aluop_q   <= active_d ? dec_aluop : 3'b000;
      npcop_q   <= active_d ? dec_npcop : 3'b000;
      extop_q   <= active_d ? dec_extop : 2'b00;
      wrsel_q   <= active_d ? dec_wrsel : 2'b00;
      wdsel_q   <= active_d ? dec_wdsel : 2'b00;
      bsel_q    <= active_d ? dec_bsel  : 1'b0;
      wbh_q     <= active_d ? dec_wbh   : 2'b00;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign PCWR    = pcwr_q;
  assign IRWR    = irwr_q;
  assign RFWR    = rfwr_q;
  assign DMWR    = dmwr_q;
  assign illegal = illegal_q;
  assign ALUOP   = aluop_q;
  assign NPCOP   = npcop_q;
  assign EXTOP   = extop_q;
  assign WRSEL   = wrsel_q;
  assign WDSEL   = wdsel_q;
  assign BSEL    = bsel_q;
  assign WBH     = wbh_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the MIPS datapath. Decodes `opcode`/`func` and walks each instruction through FETCH/DECODE/EXEC/MEM/WB states. Drives the datapath's control inputs (RFWR, DMWR, ALUOP, NPCOP, EXTOP, WRSEL, WDSEL, BSEL, WBH) plus PC- and IR-write enables. The datapath is thereby run as a multi-cycle machine. Also provides run/idle gating, an illegal-instruction pulse and a retired-instruction counter for the bench.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: permit fetch; sampled only in IDLE and at instruction boundaries.
- `opcode` in 6: instr[31:26] from IFU.
- `func` in 6: instr[5:0] from IFU.
- `zero` in 1: ALU equality flag.
- `PCWR` out 1: PC update enable (npc → pc).
- `IRWR` out 1: instruction-register load enable.
- `RFWR` out 1: GRF write enable.
- `DMWR` out 1: DM write enable.
- `ALUOP` out 3: 000 add, 001 sub, 010 or, 011 sll, 100 pass-B.
- `NPCOP` out 3: 000 pc+4, 001 beq (taken iff zero), 010 imm26 jump, 011 jr (RA).
- `EXTOP` out 2: 00 zero-ext, 01 sign-ext, 10 imm16<<16.
- `WRSEL` out 2: 00 rt, 01 rd, 10 $31.
- `WDSEL` out 2: 00 aluC, 01 dmout, 10 pc4.
- `BSEL` out 1: 0 RD2, 1 imm32.
- `WBH` out 2: 00 word, 01 byte, 10 half.
- `state` out 3: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `retired` out 32: count of completed instructions, wraps 0xFFFFFFFF→0.

## Operation
- Supported instructions:
  - R-type (opcode 0): addu (func 100001), subu (100011), sll (000000), jr (001000).
  - I/J-type: ori 001101, lui 001111, lw 100011, sw 101011, lb 100000, lh 100001, sb 101000, sh 101001, beq 000100, j 000010, jal 000011.
- FETCH: IRWR=1. Latch opcode/func into internal registers. All later decode uses the latched copy only.
- State sequences; the last state listed is the instruction's final cycle:
  - addu/subu/sll/ori/lui: F,D,E,W.
  - lw/lb/lh: F,D,E,M,W.
  - sw/sb/sh: F,D,E,M.
  - beq/j/jr: F,D,E.
  - jal: F,D,E,W.
- Static control fields (ALUOP, EXTOP, BSEL, WRSEL, WDSEL, WBH, NPCOP) are driven from the latched instruction in DECODE through the final cycle. They are 0 in IDLE/FETCH.
- Per-instruction values:
  - addu: ALUOP add, WRSEL rd.
  - subu: ALUOP sub, WRSEL rd.
  - sll: ALUOP sll, WRSEL rd.
  - ori: or, BSEL=1, EXTOP zero-ext, WRSEL rt.
  - lui: pass-B, BSEL=1, EXTOP upper, WRSEL rt.
  - loads/stores: add, BSEL=1, EXTOP sign-ext; WBH per width; loads also WDSEL dmout, WRSEL rt.
  - beq: sub, NPCOP 001.
  - j: NPCOP 010.
  - jal: NPCOP 010, WRSEL $31, WDSEL pc4.
  - jr: NPCOP 011.
- Strobes (one cycle, Moore on state):
  - RFWR only in WB.
  - DMWR only in MEM for stores.
  - PCWR only in the final cycle of each instruction, so pc/pc4 are stable throughout the instruction.
- Illegal opcode/func: sequence F,D,E with no RFWR/DMWR; PCWR=1 with NPCOP 000 in E; `illegal`=1 in that E cycle.
- `retired` increments by 1 on every cycle where PCWR=1, including illegal instructions.
- After the final cycle: go to FETCH if run=1, else IDLE. IDLE→FETCH when run=1.
- Deasserting run mid-instruction does not abort the instruction; it completes.

## Timing
- Reset (async, reset=0):
  - state=IDLE.
  - All outputs 0, retired=0.
  - Latched opcode/func=0.
  - Takes effect immediately, including mid-instruction; no partial writes afterward.
- Release of reset is synchronous to the next clk edge. The first FETCH is one cycle after run is seen high in IDLE.
- All outputs are registered-state Moore decodes; no combinational path from opcode/func/zero to any output.
- `zero` is consumed only by the datapath via NPCOP. The controller never branches its FSM on `zero`.
- CPI:
  - 3: beq, j, jr, illegal.
  - 4: ALU ops, stores, jal.
  - 5: loads.
- Back-to-back instructions with run=1 have no idle cycles.

## Test plan
- Reset: hold reset=0 with run=1 and toggle clk → state=0, every output 0, retired=0. Release reset → IDLE then FETCH, IRWR=1.
- ori then addu with run=1:
  - ori: states 1,2,3,5; RFWR=1 only in cycle 4 with WRSEL=00, BSEL=1, EXTOP=00.
  - addu follows immediately, WRSEL=01.
  - retired=2 after 8 cycles.
- lw then sw:
  - lw: WB has RFWR=1, WDSEL=01, WBH=00.
  - sw: ends in MEM with DMWR=1, PCWR=1, RFWR never asserted.
  - Total 9 cycles.
- beq with zero=1 and with zero=0 → 3 cycles each, NPCOP=001, PCWR only in EXEC, no RFWR/DMWR.
- jal then jr:
  - jal: WB has RFWR=1, WRSEL=10, WDSEL=10, NPCOP=010.
  - jr: EXEC has NPCOP=011.
- Illegal opcode 111111 → `illegal` pulses in EXEC, PCWR with NPCOP=000, retired+1.
- Drop run mid-lw → lw completes, then IDLE. Pulse reset=0 mid-EXEC → outputs 0 immediately.
- Counter wrap: force retired to 0xFFFFFFFF, retire one → retired=0.
